// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared encodings for the write-back stage.
//   - WB_SEL_*  : write-back source select codes (wb_sel input)
//   - LD_*      : load format codes (load_type input)
// Any code not listed here is handled by the consumer's default branch:
// wb_sel 11 behaves as ALU, unknown load_type codes behave as word loads.
// ----------------------------------------------------------------------------
package wb_pkg;

    // Write-back source select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    // Load formats
    localparam logic [2:0] LD_WORD   = 3'b000;
    localparam logic [2:0] LD_BYTE_S = 3'b001;
    localparam logic [2:0] LD_BYTE_U = 3'b010;
    localparam logic [2:0] LD_HALF_S = 3'b011;
    localparam logic [2:0] LD_HALF_U = 3'b100;

endpackage : wb_pkg

// File: rtl/load_extender.sv
// ----------------------------------------------------------------------------
// load_extender
// Purely combinational lane selection and sign/zero extension of load data.
// Lanes are little-endian: lane k is mem_data_i[8k+7:8k].
//
// Ports
//   mem_data_i   in  DATA_W  raw data returned by the memory stage
//   load_type_i  in  3       load format (wb_pkg LD_* codes)
//   byte_off_i   in  OFF_W   low address bits of the load
//   ext_data_o   out DATA_W  selected lane(s), extended to DATA_W
// ----------------------------------------------------------------------------
module load_extender
    import wb_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [2:0]        load_type_i,
    input  logic [OFF_W-1:0]  byte_off_i,
    output logic [DATA_W-1:0] ext_data_o
);

    logic [DATA_W-1:0] byte_shift;
    logic [DATA_W-1:0] half_shift;
    logic [OFF_W-2:0]  half_idx;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [DATA_W-1:0] word_val;

    // Shift the addressed lane down to bit 0; the shift amount is the byte
    // offset times 8 (bytes) or the half index times 16 (halves).
    // byte_off_i[0] is deliberately dropped for halves.
    assign half_idx   = byte_off_i[OFF_W-1:1];
    assign byte_shift = mem_data_i >> {byte_off_i, 3'b000};
    assign half_shift = mem_data_i >> {half_idx, 4'b0000};
    assign byte_val   = byte_shift[7:0];
    assign half_val   = half_shift[15:0];

    // On a 64-bit datapath a word load picks one 32-bit half by the top
    // offset bit and sign-extends it; on 32 bits the word is the whole bus.
    generate
        if (DATA_W == 64) begin : g_word64
            assign word_val = byte_off_i[OFF_W-1]
                ? {{32{mem_data_i[DATA_W-1]}}, mem_data_i[DATA_W-1:32]}
                : {{32{mem_data_i[31]}}, mem_data_i[31:0]};
        end else begin : g_word32
            assign word_val = mem_data_i;
        end
    endgenerate

    always_comb begin
        ext_data_o = word_val;
        case (load_type_i)
            LD_BYTE_S: ext_data_o = {{(DATA_W-8){byte_val[7]}}, byte_val};
            LD_BYTE_U: ext_data_o = {{(DATA_W-8){1'b0}}, byte_val};
            LD_HALF_S: ext_data_o = {{(DATA_W-16){half_val[15]}}, half_val};
            LD_HALF_U: ext_data_o = {{(DATA_W-16){1'b0}}, half_val};
            default:   ext_data_o = word_val;
        endcase
    end

endmodule : load_extender

// File: rtl/writeback_unit.sv
// ----------------------------------------------------------------------------
// writeback_unit
// Final pipeline stage: selects the write-back source, holds one beat in a
// pipeline register with a valid/ready handshake, drives the register-file
// write port and counts retired beats.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   in_valid / in_ready              MEM-stage beat handshake
//   flush                            drop the incoming beat this cycle
//   alu_result, mem_data, pc_plus4   candidate write-back sources
//   wb_sel, load_type, byte_off      source select and load format
//   reg_write, rd_addr               write enable and destination register
//   rf_busy                          register-file write port unavailable
//   rf_we, rf_waddr, rf_wdata        register-file write / forwarding port
//   out_valid                        pipeline register holds a beat
//   retire_cnt                       free-running count of retired beats
// ----------------------------------------------------------------------------
module writeback_unit
    import wb_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int REG_AW = 5,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        load_type,
    input  logic [OFF_W-1:0]  byte_off,
    input  logic              reg_write,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              rf_busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              out_valid,
    output logic [31:0]       retire_cnt
);

    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic              retire;

    logic              valid_q,  valid_d;
    logic              we_q,     we_d;
    logic [REG_AW-1:0] rd_q,     rd_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [31:0]       cnt_q,    cnt_d;

    load_extender #(
        .DATA_W (DATA_W)
    ) u_load_extender (
        .mem_data_i  (mem_data),
        .load_type_i (load_type),
        .byte_off_i  (byte_off),
        .ext_data_o  (ext_data)
    );

    // Source mux; the reserved select code falls through to the ALU result.
    always_comb begin
        sel_data = alu_result;
        case (wb_sel)
            WB_SEL_MEM: sel_data = ext_data;
            WB_SEL_PC4: sel_data = pc_plus4;
            default:    sel_data = alu_result;
        endcase
    end

    // A held beat leaves whenever the write port is free, so the register
    // can take a new beat in that same cycle without a bubble.
    assign in_ready = !valid_q || !rf_busy;
    assign accept   = in_valid && in_ready && !flush;
    assign retire   = valid_q && !rf_busy;

    // Next-state for the pipeline register and retire counter. Retire clears
    // valid first; an accept on the same edge then reloads it.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        rd_d    = rd_q;
        data_d  = data_q;
        cnt_d   = cnt_q + {31'd0, retire};
        if (retire) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            valid_d = 1'b1;
            we_d    = reg_write;
            rd_d    = rd_addr;
            data_d  = sel_data;
        end
    end

    // State register; reset discards any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= 32'd0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Writes to x0 still retire but never reach the register file.
    assign rf_we      = retire && we_q && (rd_q != '0);
    assign rf_waddr   = rd_q;
    assign rf_wdata   = data_q;
    assign out_valid  = valid_q;
    assign retire_cnt = cnt_q;

endmodule : writeback_unit

// File: tb/tb_writeback_unit.sv
// ----------------------------------------------------------------------------
// tb_writeback_unit
// Directed test bench for writeback_unit (DATA_W=32, REG_AW=5).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_plus4;
    logic [1:0]  wb_sel;
    logic [2:0]  load_type;
    logic [1:0]  byte_off;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic        rf_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        out_valid;
    logic [31:0] retire_cnt;

    int          testsRun;
    int          testsFailed;
    logic [31:0] expCnt;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [31:0] mem;
        logic [31:0] exp;
    } ld_vec_t;

    writeback_unit #(
        .DATA_W (32),
        .REG_AW (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .pc_plus4   (pc_plus4),
        .wb_sel     (wb_sel),
        .load_type  (load_type),
        .byte_off   (byte_off),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .rf_busy    (rf_busy),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .out_valid  (out_valid),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] sel, input logic [2:0] lt,
                           input logic [1:0] off, input logic [31:0] alu,
                           input logic [31:0] mem, input logic rw,
                           input logic [4:0] rd);
        in_valid   = 1'b1;
        wb_sel     = sel;
        load_type  = lt;
        byte_off   = off;
        alu_result = alu;
        mem_data   = mem;
        reg_write  = rw;
        rd_addr    = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rf_busy = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        expCnt = 32'd0;
        testsRun++;
        if (out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        testsRun++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_port: got we=%b addr=%0d data=%h expected 0/0/0",
                     rf_we, rf_waddr, rf_wdata);
        end
        testsRun++;
        if (retire_cnt !== 32'd0 || in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_cnt_ready: got cnt=%h ready=%b expected 0/1",
                     retire_cnt, in_ready);
        end
    endtask

    task automatic test_alu();
        present(2'b00, 3'b000, 2'd0, 32'h0000_1234, 32'h0, 1'b1, 5'd5);
        step();
        idle();
        #1;
        testsRun++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h0000_1234) begin
            testsFailed++;
            $display("[TB] FAIL alu_write: got we=%b addr=%0d data=%h expected 1/5/00001234",
                     rf_we, rf_waddr, rf_wdata);
        end
        step();
        expCnt = expCnt + 1;
        testsRun++;
        if (retire_cnt !== expCnt || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL alu_retire: got cnt=%h valid=%b expected %h/0",
                     retire_cnt, out_valid, expCnt);
        end
    endtask

    task automatic test_loads();
        ld_vec_t vecs[14];
        vecs[0]  = '{2'b01, 3'b001, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80};
        vecs[1]  = '{2'b01, 3'b010, 2'd3, 32'h80FF_7F01, 32'h0000_0080};
        vecs[2]  = '{2'b01, 3'b011, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
        vecs[3]  = '{2'b01, 3'b011, 2'd3, 32'h8001_0000, 32'hFFFF_8001};
        vecs[4]  = '{2'b01, 3'b100, 2'd2, 32'h8001_0000, 32'h0000_8001};
        vecs[5]  = '{2'b01, 3'b001, 2'd1, 32'h80FF_7F01, 32'h0000_007F};
        vecs[6]  = '{2'b01, 3'b010, 2'd2, 32'h80FF_7F01, 32'h0000_00FF};
        vecs[7]  = '{2'b01, 3'b011, 2'd1, 32'h80FF_7F01, 32'h0000_7F01};
        vecs[8]  = '{2'b01, 3'b000, 2'd3, 32'h80FF_7F01, 32'h80FF_7F01};
        vecs[9]  = '{2'b01, 3'b111, 2'd0, 32'h80FF_7F01, 32'h80FF_7F01};
        vecs[10] = '{2'b10, 3'b001, 2'd3, 32'h80FF_7F01, 32'h0000_0080};
        vecs[11] = '{2'b11, 3'b001, 2'd3, 32'h80FF_7F01, 32'hA5A5_0011};
        vecs[12] = '{2'b00, 3'b011, 2'd2, 32'h80FF_7F01, 32'hA5A5_0011};
        vecs[13] = '{2'b01, 3'b011, 2'd0, 32'h0000_FFFE, 32'hFFFF_FFFE};
        pc_plus4 = 32'h0000_0080;
        for (int i = 0; i < 14; i++) begin
            present(vecs[i].sel, vecs[i].lt, vecs[i].off, 32'hA5A5_0011,
                    vecs[i].mem, 1'b1, 5'd7);
            step();
            if (i > 0) expCnt = expCnt + 1;
            testsRun++;
            if (rf_wdata !== vecs[i].exp || rf_we !== 1'b1 || out_valid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL load_vec%0d: got data=%h we=%b valid=%b expected %h/1/1",
                         i, rf_wdata, rf_we, out_valid, vecs[i].exp);
            end
        end
        idle();
        step();
        expCnt = expCnt + 1;
        testsRun++;
        if (retire_cnt !== expCnt || out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL load_retire_count: got cnt=%h valid=%b expected %h/0",
                     retire_cnt, out_valid, expCnt);
        end
    endtask

    task automatic test_back_to_back();
        present(2'b00, 3'b000, 2'd0, 32'h0000_0111, 32'h0, 1'b1, 5'd3);
        step();
        rf_busy = 1'b1;
        present(2'b00, 3'b000, 2'd0, 32'h0000_0222, 32'h0, 1'b1, 5'd4);
        for (int c = 0; c < 3; c++) begin
            #1;
            testsRun++;
            if (in_ready !== 1'b0 || rf_we !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL stall_handshake%0d: got ready=%b we=%b expected 0/0",
                         c, in_ready, rf_we);
            end
            step();
            testsRun++;
            if (out_valid !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h0000_0111
                || retire_cnt !== expCnt) begin
                testsFailed++;
                $display("[TB] FAIL stall_hold%0d: got valid=%b addr=%0d data=%h cnt=%h expected 1/3/00000111/%h",
                         c, out_valid, rf_waddr, rf_wdata, retire_cnt, expCnt);
            end
        end
        rf_busy = 1'b0;
        #1;
        testsRun++;
        if (in_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
            testsFailed++;
            $display("[TB] FAIL stall_release: got ready=%b we=%b addr=%0d expected 1/1/3",
                     in_ready, rf_we, rf_waddr);
        end
        step();
        idle();
        expCnt = expCnt + 1;
        testsRun++;
        if (out_valid !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h0000_0222
            || retire_cnt !== expCnt) begin
            testsFailed++;
            $display("[TB] FAIL no_bubble: got valid=%b addr=%0d data=%h cnt=%h expected 1/4/00000222/%h",
                     out_valid, rf_waddr, rf_wdata, retire_cnt, expCnt);
        end
        step();
        expCnt = expCnt + 1;
    endtask

    task automatic test_rd_zero_flush();
        present(2'b00, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd0);
        step();
        idle();
        #1;
        testsRun++;
        if (rf_we !== 1'b0 || out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rd_zero_we: got we=%b valid=%b expected 0/1", rf_we, out_valid);
        end
        step();
        expCnt = expCnt + 1;
        testsRun++;
        if (retire_cnt !== expCnt) begin
            testsFailed++;
            $display("[TB] FAIL rd_zero_count: got %h expected %h", retire_cnt, expCnt);
        end
        present(2'b00, 3'b000, 2'd0, 32'h0000_0055, 32'h0, 1'b1, 5'd9);
        flush = 1'b1;
        step();
        idle();
        testsRun++;
        if (out_valid !== 1'b0 || retire_cnt !== expCnt) begin
            testsFailed++;
            $display("[TB] FAIL flush_drop: got valid=%b cnt=%h expected 0/%h",
                     out_valid, retire_cnt, expCnt);
        end
        present(2'b00, 3'b000, 2'd0, 32'h0000_0066, 32'h0, 1'b0, 5'd10);
        step();
        testsRun++;
        if (rf_we !== 1'b0 || out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL no_regwrite_we: got we=%b valid=%b expected 0/1", rf_we, out_valid);
        end
        present(2'b00, 3'b000, 2'd0, 32'h0000_0077, 32'h0, 1'b1, 5'd11);
        flush = 1'b1;
        step();
        idle();
        expCnt = expCnt + 1;
        testsRun++;
        if (out_valid !== 1'b0 || retire_cnt !== expCnt) begin
            testsFailed++;
            $display("[TB] FAIL flush_held_retires: got valid=%b cnt=%h expected 0/%h",
                     out_valid, retire_cnt, expCnt);
        end
    endtask

    task automatic test_wrap_and_reset();
        present(2'b00, 3'b000, 2'd0, 32'h0000_0099, 32'h0, 1'b1, 5'd12);
        step();
        idle();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        testsRun++;
        if (retire_cnt !== 32'hFFFF_FFFF) begin
            testsFailed++;
            $display("[TB] FAIL wrap_preload: got %h expected ffffffff", retire_cnt);
        end
        step();
        testsRun++;
        if (retire_cnt !== 32'h0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL wrap_to_zero: got %h expected 00000000", retire_cnt);
        end
        present(2'b00, 3'b000, 2'd0, 32'h0000_0ABC, 32'h0, 1'b1, 5'd13);
        step();
        rf_busy = 1'b1;
        step();
        rst = 1'b1;
        present(2'b00, 3'b000, 2'd0, 32'h0000_0DEF, 32'h0, 1'b1, 5'd14);
        step();
        rst = 1'b0;
        rf_busy = 1'b0;
        idle();
        #1;
        testsRun++;
        if (out_valid !== 1'b0 || rf_we !== 1'b0 || rf_waddr !== 5'd0
            || rf_wdata !== 32'd0 || retire_cnt !== 32'd0 || in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_stall: got valid=%b we=%b addr=%0d data=%h cnt=%h ready=%b expected 0/0/0/0/0/1",
                     out_valid, rf_we, rf_waddr, rf_wdata, retire_cnt, in_ready);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        expCnt      = 32'd0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        flush       = 1'b0;
        alu_result  = 32'd0;
        mem_data    = 32'd0;
        pc_plus4    = 32'd0;
        wb_sel      = 2'b00;
        load_type   = 3'b000;
        byte_off    = 2'd0;
        reg_write   = 1'b0;
        rd_addr     = 5'd0;
        rf_busy     = 1'b0;
        #2;
        test_reset();
        test_alu();
        test_loads();
        test_back_to_back();
        test_rd_zero_flush();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_writeback_unit

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL define derived constant OFF_W = log2(DATA_W/8), the byte-offset width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  MEM-stage beat present.
REQ-007 in_ready  out  1  unit accepts the beat this cycle.
REQ-008 flush  in  1  drop the incoming beat this cycle.
REQ-009 alu_result, mem_data, pc_plus4  in  DATA_W each  candidate write-back sources.
REQ-010 wb_sel  in  2  source select: 00 ALU, 01 MEM, 10 PC+4 (link), 11 reserved, treated as ALU.
REQ-011 load_type  in  3  load format: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; other codes treated as word.
REQ-012 byte_off  in  OFF_W  low address bits of the load.
REQ-013 reg_write, rd_addr  in  1, REG_AW  write enable and destination register.
REQ-014 rf_busy  in  1  register-file write port unavailable this cycle.
REQ-015 rf_we, rf_waddr, rf_wdata  out  1, REG_AW, DATA_W  register-file write port; these also drive forwarding.
REQ-016 out_valid  out  1  pipeline register holds a beat.
REQ-017 retire_cnt  out  32  count of retired beats.

Function
REQ-018 Accept SHALL occur when in_valid && in_ready && !flush; the selected and extended data, rd_addr and reg_write are captured into the pipeline register on that edge (1-cycle latency).
REQ-019 in_ready SHALL equal !out_valid || !rf_busy (combinational); a beat arriving while in_ready=0 is neither captured nor lost, because upstream holds it.
REQ-020 Retire SHALL occur in any cycle where out_valid && !rf_busy; out_valid clears on that edge unless an accept occurs on the same edge, in which case the register reloads with no bubble.
REQ-021 rf_we SHALL equal out_valid && !rf_busy && held reg_write && (held rd_addr != 0); rf_waddr and rf_wdata SHALL present held values whenever out_valid=1.
REQ-022 While rf_busy=1, the held beat SHALL remain unchanged for any number of cycles.
REQ-023 Load extraction: byte lane k = mem_data[8k+7:8k], little-endian. A byte load uses lane byte_off. A half load uses lanes {2h+1,2h}, with h = byte_off[OFF_W-1:1]; byte_off[0] is ignored. A word load with DATA_W=64 selects the 32-bit half given by byte_off[2] and sign-extends it.
REQ-024 Signed formats SHALL sign-extend to DATA_W; unsigned formats SHALL zero-extend. Extension applies only when wb_sel=01.
REQ-025 flush SHALL suppress capture of the current input beat only; a beat already held still retires normally.
REQ-026 retire_cnt SHALL increment by 1 per retire, including beats with reg_write=0, and wrap from FFFF_FFFF to 0.

Reset
REQ-027 On rst, out_valid, rf_we, rf_waddr, rf_wdata and retire_cnt SHALL clear to 0; in_ready is then 1.
REQ-028 rst SHALL take priority over simultaneous accept, retire and flush; a beat held mid-stall is discarded without writing.

Structure
REQ-029 The wb_sel and load_type encodings SHALL reside as named constants in shared package wb_pkg.
REQ-030 Lane selection and extension SHALL be a combinational sub-module load_extender, parameterised by DATA_W.
REQ-031 The top level SHALL contain only the source mux, the pipeline register with handshake, and the retire counter.

Verification
REQ-032 ALU path: wb_sel=00, alu_result=0000_1234, rd=5, reg_write=1 -> next cycle rf_we=1, waddr=5, wdata=0000_1234, retire_cnt=1.
REQ-033 Signed byte load: wb_sel=01, load_type=001, mem_data=80FF_7F01, byte_off=3 -> wdata=FFFF_FF80; with load_type=010 -> 0000_0080.
REQ-034 Half load: load_type=011, mem_data=8001_0000, byte_off=2 -> FFFF_8001; same with byte_off=3 -> FFFF_8001.
REQ-035 Stall: hold rf_busy=1 for 3 cycles with a beat held and another beat presented -> in_ready=0, rf_we=0, held values stable; on release, first beat writes, second beat accepted same edge, no bubble.
REQ-036 rd_addr=0 with reg_write=1, and separately flush with in_valid=1 -> first: rf_we=0 but retire_cnt increments; second: nothing captured, out_valid stays 0.
REQ-037 Preload retire_cnt to FFFF_FFFF, retire one beat -> 0; assert rst with a beat held under rf_busy -> all outputs 0 next cycle, no write.
